// File: rtl/pf_pkg.sv
// Shared definitions for the prefetch fill path: address widths, FSM states and a
// constant-evaluable log2 helper used to size pointers and counters.
package pf_pkg;

  localparam int ADDR_WIDTH    = 32;
  localparam int DUP_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pf_req_fifo.sv
// Circular request FIFO with synchronous clear, plus a per-entry match vector that
// flags every live entry equal to cmp_addr (used to filter duplicate prefetches).
module pf_req_fifo
  import pf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  logic [WIDTH-1:0]        push_data,
  input  logic [WIDTH-1:0]        cmp_addr,
  output logic [WIDTH-1:0]        head_data,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]        match_vec
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  // An entry is live when its distance from the read pointer is below the fill count.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(PW'(PW'(i) - rd_ptr)) < count) && (mem[i] == cmp_addr)) begin
        match_vec[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prefetch_fill_responder.sv
// Memory-side responder for next-line prefetches: queues unique block addresses, models a
// fixed memory latency and returns one fill response per request in arrival order.
module prefetch_fill_responder
  import pf_pkg::*;
#(
  parameter int block_size_byte    = 16,
  parameter int block_offset_index = clog2(block_size_byte),
  parameter int blk_width          = ADDR_WIDTH - block_offset_index,
  parameter int QUEUE_DEPTH        = 4,
  parameter int MEM_LATENCY        = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [blk_width-1:0]     req_block_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [blk_width-1:0]     resp_block_addr,
  input  logic                     flush,
  output logic                     busy,
  output logic [DUP_CNT_WIDTH-1:0] dup_count
);

  localparam int CNT_W = clog2(MEM_LATENCY + 1);
  localparam int QC_W  = clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t               state;
  logic [CNT_W-1:0]     lat_cnt;
  logic [blk_width-1:0] serv_addr;
  logic [blk_width-1:0] head_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [QC_W-1:0]      fifo_count;
  logic [QUEUE_DEPTH-1:0] match_vec;
  logic                 accept;
  logic                 dup_hit;
  logic                 push;
  logic                 pop;
  logic                 resp_hs;

  assign req_ready = !fifo_full && !flush;
  assign accept    = req_valid && req_ready;
  assign dup_hit   = (|match_vec) || ((state != S_IDLE) && (serv_addr == req_block_addr));
  assign push      = accept && !dup_hit;
  assign resp_hs   = resp_valid && resp_ready;
  assign pop       = !flush && !fifo_empty &&
                     ((state == S_IDLE) || ((state == S_RESP) && resp_hs));
  assign busy      = (state != S_IDLE) || (fifo_count != '0);

  pf_req_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (blk_width)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .clear     (flush),
    .push_data (req_block_addr),
    .cmp_addr  (req_block_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .match_vec (match_vec)
  );

  // Back-to-back service: a completed response pops the next entry on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      lat_cnt         <= '0;
      serv_addr       <= '0;
      resp_valid      <= 1'b0;
      resp_block_addr <= '0;
      dup_count       <= '0;
    end else begin
      if (accept && dup_hit && (dup_count != '1)) dup_count <= dup_count + 1'b1;
      if (flush) begin
        state      <= S_IDLE;
        resp_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (pop) begin
              serv_addr <= head_data;
              lat_cnt   <= LAT_LOAD;
              state     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (lat_cnt == '0) begin
              state           <= S_RESP;
              resp_valid      <= 1'b1;
              resp_block_addr <= serv_addr;
            end else begin
              lat_cnt <= lat_cnt - 1'b1;
            end
          end
          S_RESP: begin
            if (resp_hs) begin
              resp_valid <= 1'b0;
              if (pop) begin
                serv_addr <= head_data;
                lat_cnt   <= LAT_LOAD;
                state     <= S_WAIT;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prefetch_fill_responder.sv
// Self-checking bench: directed scenarios plus random traffic, all compared each cycle
// against a timeline model of outstanding requests (queue + service start edge).
module tb_prefetch_fill_responder;

  localparam int BW    = 28;
  localparam int LAT   = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [BW-1:0] req_block_addr = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [BW-1:0] resp_block_addr;
  logic          flush = 1'b0;
  logic          busy;
  logic [15:0]   dup_count;

  prefetch_fill_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_block_addr  (req_block_addr),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_block_addr (resp_block_addr),
    .flush           (flush),
    .busy            (busy),
    .dup_count       (dup_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: oq holds every accepted, not-yet-returned address; oq[0] is in service when start_edge>=0.
  logic [BW-1:0] oq[$];
  int            start_edge = -1;
  int            edge_no = 0;
  int            m_dup = 0;
  logic [BW-1:0] m_last = '0;

  logic [BW-1:0] got_addr[$];
  int            got_edge[$];
  logic          obs_rv, obs_ready, obs_busy;
  logic [15:0]   obs_dup;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s edge=%0d observed=0x%0h expected=0x%0h", tag, edge_no, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [BW-1:0] a, input logic rr, input logic fl);
    logic in_svc, exp_ready, exp_rv, hs, acc, dup;
    int   fifo_cnt;
    @(negedge clk);
    req_valid = v; req_block_addr = a; resp_ready = rr; flush = fl;
    #1;
    in_svc    = (start_edge >= 0);
    fifo_cnt  = oq.size() - (in_svc ? 1 : 0);
    exp_ready = (fifo_cnt < DEPTH) && !fl;
    exp_rv    = in_svc && (edge_no >= start_edge + LAT);
    if (exp_rv) m_last = oq[0];
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("resp_valid", 32'(resp_valid), 32'(exp_rv));
    checkOutput("resp_block_addr", 32'(resp_block_addr), 32'(m_last));
    checkOutput("busy", 32'(busy), 32'(oq.size() > 0));
    checkOutput("dup_count", 32'(dup_count), 32'(m_dup));
    obs_rv = resp_valid; obs_ready = req_ready; obs_busy = busy; obs_dup = dup_count;
    if (resp_valid && rr && !fl) begin
      got_addr.push_back(resp_block_addr);
      got_edge.push_back(edge_no + 1);
    end
    @(posedge clk);
    edge_no++;
    if (fl) begin
      oq.delete();
      start_edge = -1;
    end else begin
      hs  = exp_rv && rr;
      acc = v && exp_ready;
      dup = 1'b0;
      foreach (oq[i]) if (oq[i] == a) dup = 1'b1;
      if (hs) begin
        void'(oq.pop_front());
        start_edge = (fifo_cnt > 0) ? edge_no : -1;
      end else if (!in_svc && fifo_cnt > 0) begin
        start_edge = edge_no;
      end
      if (acc && !dup) oq.push_back(a);
      if (acc && dup && m_dup < 65535) m_dup++;
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; flush = 1'b0;
    #1;
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_dup_count", 32'(dup_count), 32'd0);
    oq.delete(); start_edge = -1; m_dup = 0; m_last = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic idleSteps(input int n, input logic rr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, rr, 1'b0);
  endtask

  initial begin
    int first, cnt, d0;

    applyReset();
    idleSteps(2, 1'b1);

    // Single request: response visible exactly 1+LAT edges after acceptance, for one cycle
    applyStimulus(1'b1, 28'h0000010, 1'b1, 1'b0);
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      if (obs_rv && first == 0) first = i;
    end
    checkOutput("single_latency", 32'(first), 32'(LAT + 2));

    // Five back-to-back pushes with backpressure: FIFO refills to full, then ordered drain
    got_addr.delete(); got_edge.delete();
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, BW'(28'h10 + k), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("full_ready", 32'(obs_ready), 32'd0);
    idleSteps(60, 1'b1);
    checkOutput("fill_count", 32'(got_addr.size()), 32'd5);
    for (int k = 0; k < 5 && k < got_addr.size(); k++) begin
      checkOutput("fill_order", 32'(got_addr[k]), 32'(28'h10 + k));
      if (k > 0) checkOutput("fill_gap", 32'(got_edge[k] - got_edge[k-1]), 32'(LAT + 1));
    end

    // Duplicates: one while queued behind 0x30, one while 0x20 is in service
    got_addr.delete(); got_edge.delete();
    d0 = m_dup;
    applyStimulus(1'b1, 28'h30, 1'b1, 1'b0);
    applyStimulus(1'b1, 28'h20, 1'b1, 1'b0);
    applyStimulus(1'b1, 28'h20, 1'b1, 1'b0);
    idleSteps(9, 1'b1);
    applyStimulus(1'b1, 28'h20, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("dup_delta", 32'(obs_dup), 32'(d0 + 2));
    idleSteps(20, 1'b1);
    cnt = 0;
    foreach (got_addr[i]) if (got_addr[i] == 28'h20) cnt++;
    checkOutput("dup_single_resp", 32'(cnt), 32'd1);

    // Backpressure: response held for 20 cycles, then delivered once
    got_addr.delete(); got_edge.delete();
    applyStimulus(1'b1, 28'h40, 1'b0, 1'b0);
    idleSteps(LAT + 1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      if (obs_rv) cnt++;
    end
    checkOutput("hold_cycles", 32'(cnt), 32'd20);
    idleSteps(3, 1'b1);
    checkOutput("hold_delivered", 32'(got_addr.size()), 32'd1);

    // Flush with one in service and three queued, plus a same-cycle request
    got_addr.delete(); got_edge.delete();
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, BW'(28'h50 + k), 1'b1, 1'b0);
    applyStimulus(1'b1, 28'h54, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("flush_busy", 32'(obs_busy), 32'd0);
    checkOutput("flush_resp_valid", 32'(obs_rv), 32'd0);
    idleSteps(30, 1'b1);
    checkOutput("flush_no_resp", 32'(got_addr.size()), 32'd0);

    // Random traffic over a small address pool to exercise duplicates, full and flush
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), BW'(28'h100 + $urandom_range(0, 7)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
    end
    idleSteps(60, 1'b1);

    // Reset while a request sits in the latency wait
    applyStimulus(1'b1, 28'h60, 1'b1, 1'b0);
    idleSteps(3, 1'b1);
    applyReset();
    idleSteps(12, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
